// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   MD_OP_W     : width of the operation code
//   MD_OP_*     : operation encodings used by md_unit and the D-stage decoder
//   is_muldiv() : true for ops that start a multi-cycle HI/LO computation
//   is_div()    : true for the divide ops (selects the divide latency)
package md_pkg;

  localparam int MD_OP_W = 3;

  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam md_op_t MD_OP_MULT  = 3'd0;
  localparam md_op_t MD_OP_MULTU = 3'd1;
  localparam md_op_t MD_OP_DIV   = 3'd2;
  localparam md_op_t MD_OP_DIVU  = 3'd3;
  localparam md_op_t MD_OP_MTHI  = 3'd4;
  localparam md_op_t MD_OP_MTLO  = 3'd5;
  localparam md_op_t MD_OP_NOP   = 3'd6;  // 3'd7 is also treated as a no-op

  // The hazard unit uses this too, so the stall decode cannot drift from
  // the encodings the unit itself accepts.
  function automatic logic is_muldiv(input md_op_t op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational divider for md_unit.
//   a, b      : dividend and divisor
//   is_signed : 1 = two's-complement divide, 0 = unsigned divide
//   quo, rem  : quotient (truncated toward zero) and remainder (sign of a)
// Divide by zero returns quo = all ones, rem = a. The signed overflow case
// MIN / -1 returns quo = MIN, rem = 0.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo_u;
  logic [WIDTH-1:0] rem_u;

  always_comb begin
    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    abs_a   = a_neg ? -a : a;
    abs_b   = b_neg ? -b : b;
    // Keep the divider operand nonzero so the datapath never produces X;
    // the zero-divisor result is substituted below.
    divisor = (b == '0) ? ONE : abs_b;
    quo_u   = abs_a / divisor;
    rem_u   = abs_a % divisor;
    quo     = (a_neg ^ b_neg) ? -quo_u : quo_u;
    rem     = a_neg ? -rem_u : rem_u;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else if (is_signed && (a == MIN_VAL) && (b == '1)) begin
      quo = MIN_VAL;
      rem = '0;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers (E stage).
//   clk, reset : clock, synchronous active-low reset
//   start, op  : issue strobe and operation code (md_pkg encodings)
//   a, b       : rs / rt operands, already forwarded
//   flush      : abort an in-flight mult/div; HI/LO keep their old values
//   busy       : issue of a mult/div this cycle, or one still counting
//   hi, lo     : architectural HI/LO registers
// Handshake: a mult/div is accepted when start=1, op is a mult/div code,
// the counter is zero and flush=0. The result is computed at issue and held
// in res_hi/res_lo; HI/LO take it on the edge where the counter goes 1->0,
// so new values are visible exactly MULT_CYCLES/DIV_CYCLES edges after the
// issue edge. Any start while the counter is nonzero is ignored.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  logic                 idle;
  logic                 issue_md;
  logic                 issue_mthi;
  logic                 issue_mtlo;
  logic                 commit;

  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   prod_u;
  logic [WIDTH-1:0]     div_quo;
  logic [WIDTH-1:0]     div_rem;
  logic [WIDTH-1:0]     new_hi;
  logic [WIDTH-1:0]     new_lo;

  assign idle       = (count == '0);
  assign issue_md   = start && !flush && idle && is_muldiv(op);
  assign issue_mthi = start && !flush && idle && (op == MD_OP_MTHI);
  assign issue_mtlo = start && !flush && idle && (op == MD_OP_MTLO);
  assign commit     = !flush && (count == CNT_ONE);

  // The hazard unit must see the stall in the issue cycle itself, before the
  // counter has been loaded.
  assign busy = (start && is_muldiv(op)) || !idle;

  // Both products at full 2*WIDTH so the sign-extended form gives the signed
  // product directly in the low 2*WIDTH bits.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  md_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .a        (a),
    .b        (b),
    .is_signed(op == MD_OP_DIV),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_comb begin
    new_hi = prod_s[2*WIDTH-1:WIDTH];
    new_lo = prod_s[WIDTH-1:0];
    case (op)
      MD_OP_MULTU: begin
        new_hi = prod_u[2*WIDTH-1:WIDTH];
        new_lo = prod_u[WIDTH-1:0];
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        new_hi = div_rem;
        new_lo = div_quo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (flush) begin
        count  <= '0;
        res_hi <= '0;
        res_lo <= '0;
      end else if (issue_md) begin
        count  <= is_div(op) ? DIV_LOAD : MULT_LOAD;
        res_hi <= new_hi;
        res_lo <= new_lo;
      end else if (!idle) begin
        count <= count - CNT_ONE;
      end

      // Commit and the move-to ops are mutually exclusive: moves need idle.
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (issue_mthi) begin
        hi <= a;
      end else if (issue_mtlo) begin
        lo <= a;
      end
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the 5-stage pipeline; sits in the E stage beside the ALU.
- Accepts one operation per issue and holds HI/LO until the operation completes.
- Exposes `busy` so the hazard unit stalls any mult/div/mfhi/mflo/mthi/mtlo in D while an operation is outstanding.
- Successor to the single-cycle, ALU-only execute path: adds width generality, configurable latencies, HI/LO state, and defined divide corner cases.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles from issue to HI/LO update for mult/multu (>=1).
- DIV_CYCLES, 10, cycles from issue to HI/LO update for div/divu (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- start  in  1  issue strobe for `op`; valid only in the cycle the instruction is in E.
- op  in  3  operation code (encodings in package).
- a  in  WIDTH  rs operand, already forwarded.
- b  in  WIDTH  rt operand, already forwarded.
- flush  in  1  abort the in-flight mult/div; HI/LO keep their old values.
- busy  out  1  start_muldiv OR count!=0; feeds the hazard-unit stall.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at posedge): hi=0, lo=0, count=0, pending result cleared, busy=0 from the next cycle. Reset mid-operation discards the result.
- Ops (3-bit): MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, NOP=6/7.
  - mfhi/mflo are not ops; they read hi/lo directly.
- Issue of mult/div: start=1, op in 0..3, count==0.
  - Result is computed from a,b and latched into res_hi/res_lo.
  - count loads MULT_CYCLES or DIV_CYCLES.
- count behaviour:
  - Decrements by 1 each cycle while nonzero.
  - On the edge where count goes 1->0: hi<=res_hi, lo<=res_lo.
  - New hi/lo are visible exactly N cycles after the issue edge (N = configured latency).
- busy:
  - Combinational: 1 in the issue cycle (start with op 0..3) and while count!=0.
  - Falls to 0 in the cycle hi/lo first show the new result.
- mthi/mtlo:
  - start=1 with op MTHI/MTLO and count==0 writes a to hi/lo at the next edge; single cycle; busy stays 0.
- start while count!=0: ignored (no state change).
  - The hazard unit guarantees this does not occur; the bench still checks it.
- flush=1: count<=0 and the pending result is discarded.
  - If start is also 1 in the same cycle, flush wins and nothing issues.
- Arithmetic:
  - mult: signed 2W-bit product, hi=upper W bits, lo=lower W bits.
  - multu: unsigned 2W-bit product, same split.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient (lo) and remainder (hi).
- Divide corner cases:
  - Divide by zero (b==0): lo=all ones; hi=a. Applies to both div and divu.
  - Signed overflow (a=MIN, b=-1, div): lo=MIN, hi=0.
- Latency-1 configs: count loads 1 and hi/lo update one edge after issue.

Decomposition:
- Package md_pkg:
  - MD_OP_* op encodings.
  - MD_OP_W=3.
  - Function is_muldiv(op) for the hazard unit, so D-stage stall decode shares the encodings.
- One sub-module md_div_core:
  - Combinational signed/unsigned divide with WIDTH parameter.
  - Handles the zero-divisor and overflow cases and returns {rem, quo}.
- Multiply stays inline.
- Top holds the counter, result latches, and HI/LO.

Test Plan:
- Reset: drive reset=0 for 2 cycles mid-divide (count=7) -> hi=0, lo=0, busy=0; the stale divide never commits.
- mult a=0xFFFFFFFE (-2), b=3, default latencies:
  - busy=1 for cycles 0..4.
  - Cycle 5: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2:
  - After 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - divu with the same operands -> lo=0x7FFFFFFC, hi=1.
- Corner cases:
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - divu a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- Interference:
  - Issue div, then at count=4 pulse start with MULT and a=b=1 -> ignored; the div result commits at cycle 10.
  - Issue mult, then flush at cycle 2 -> busy=0 next cycle and hi/lo unchanged.
  - mthi a=0x1234 -> hi=0x1234 next edge with busy=0 throughout.
